ifft32_bfly_sched: RTL and testbench

Sequencer for one shared radix-2 butterfly (bfly2, 36-bit re/im lanes) in the in-place, memory-based 32-point IFFT. On start it steps through 5 stages × 16 butterflies. Each cycle it issues a dual read address pair and a twiddle index. It tracks data through RAM read latency and butterfly latency, then issues the matching write-back address pair. A stage boundary stalls until the previous stage has fully written back. Input data is loaded into RAM in bit-reversed order before start; loading is outside this block.

---
 rtl/ifft32_bfly_sched.sv | 149 ++++++++++++++
 tb/tb_ifft32_bfly_sched.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifft32_bfly_sched.sv
// Address/twiddle sequencer for one shared radix-2 butterfly in an in-place 32-point IFFT.
// Reads 16 butterflies per stage, drains the read+butterfly pipeline, then moves to the next stage.
module ifft32_bfly_sched #(
    parameter int RD_LAT   = 1,
    parameter int BFLY_LAT = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic [2:0] stage,
    output logic       rd_en,
    output logic [4:0] rd_addr_a,
    output logic [4:0] rd_addr_b,
    output logic [3:0] tw_idx,
    output logic       wr_en,
    output logic [4:0] wr_addr_a,
    output logic [4:0] wr_addr_b
);

    localparam int D   = RD_LAT + BFLY_LAT;
    localparam int DCW = (D > 1) ? $clog2(D) : 1;

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    state_t         state;
    logic [3:0]     k;
    logic [DCW-1:0] drain_cnt;

    // Returns {addr_a, addr_b, tw} for butterfly kk of stage s.
    function automatic logic [13:0] bfly_addr(input logic [2:0] s, input logic [3:0] kk);
        logic [4:0] span;
        logic [4:0] grp;
        logic [4:0] pos;
        logic [4:0] a;
        logic [4:0] b;
        logic [3:0] tw;
        span = 5'd1 << s;
        grp  = {1'b0, kk} >> s;
        pos  = {1'b0, kk} & (span - 5'd1);
        a    = (grp << (s + 3'd1)) | pos;
        b    = a + span;
        tw   = 4'(pos << (3'd4 - s));
        return {a, b, tw};
    endfunction

    // Read-side outputs are computed from the next k/stage so they are registered, not decoded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            stage     <= '0;
            k         <= '0;
            drain_cnt <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            rd_en     <= 1'b0;
            rd_addr_a <= '0;
            rd_addr_b <= '0;
            tw_idx    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= READ;
                        stage <= '0;
                        k     <= '0;
                        busy  <= 1'b1;
                        rd_en <= 1'b1;
                        {rd_addr_a, rd_addr_b, tw_idx} <= bfly_addr(3'd0, 4'd0);
                    end
                end
                READ: begin
                    if (k == 4'd15) begin
                        k         <= '0;
                        drain_cnt <= '0;
                        state     <= DRAIN;
                        rd_en     <= 1'b0;
                        {rd_addr_a, rd_addr_b, tw_idx} <= '0;
                    end else begin
                        k <= k + 4'd1;
                        {rd_addr_a, rd_addr_b, tw_idx} <= bfly_addr(stage, k + 4'd1);
                    end
                end
                DRAIN: begin
                    // The last write-back of this stage lands on the final drain cycle.
                    if (drain_cnt == DCW'(D - 1)) begin
                        if (stage == 3'd4) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            stage <= stage + 3'd1;
                            state <= READ;
                            rd_en <= 1'b1;
                            {rd_addr_a, rd_addr_b, tw_idx} <= bfly_addr(stage + 3'd1, 4'd0);
                        end
                    end else begin
                        drain_cnt <= drain_cnt + DCW'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    logic [D-1:0] pipe_v;
    logic [4:0]   pipe_a [D];
    logic [4:0]   pipe_b [D];

    generate
        for (genvar gi = 0; gi < D; gi++) begin : g_wb
            if (gi == 0) begin : g_head
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        pipe_v[gi] <= 1'b0;
                        pipe_a[gi] <= '0;
                        pipe_b[gi] <= '0;
                    end else begin
                        pipe_v[gi] <= rd_en;
                        pipe_a[gi] <= rd_addr_a;
                        pipe_b[gi] <= rd_addr_b;
                    end
                end
            end else begin : g_tail
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        pipe_v[gi] <= 1'b0;
                        pipe_a[gi] <= '0;
                        pipe_b[gi] <= '0;
                    end else begin
                        pipe_v[gi] <= pipe_v[gi-1];
                        pipe_a[gi] <= pipe_a[gi-1];
                        pipe_b[gi] <= pipe_b[gi-1];
                    end
                end
            end
        end
    endgenerate

    assign wr_en     = pipe_v[D-1];
    assign wr_addr_a = pipe_a[D-1];
    assign wr_addr_b = pipe_b[D-1];

endmodule

// File: tb/tb_ifft32_bfly_sched.sv
// Bench for ifft32_bfly_sched: per-cycle comparison against a schedule model built from
// nested FFT loops, a spot-check vector table, and hand sequences for reset and held start.
module tb_ifft32_bfly_sched;

    logic       clk;
    logic       rst;
    logic       start;
    logic       start2;

    logic       busy1, done1, rd_en1, wr_en1;
    logic [2:0] stage1;
    logic [4:0] rd_a1, rd_b1, wr_a1, wr_b1;
    logic [3:0] tw1;

    logic       busy2, done2, rd_en2, wr_en2;
    logic [2:0] stage2;
    logic [4:0] rd_a2, rd_b2, wr_a2, wr_b2;
    logic [3:0] tw2;

    ifft32_bfly_sched dut (
        .clk(clk), .rst(rst), .start(start),
        .busy(busy1), .done(done1), .stage(stage1),
        .rd_en(rd_en1), .rd_addr_a(rd_a1), .rd_addr_b(rd_b1), .tw_idx(tw1),
        .wr_en(wr_en1), .wr_addr_a(wr_a1), .wr_addr_b(wr_b1)
    );

    ifft32_bfly_sched #(.RD_LAT(2), .BFLY_LAT(3)) dut2 (
        .clk(clk), .rst(rst), .start(start2),
        .busy(busy2), .done(done2), .stage(stage2),
        .rd_en(rd_en2), .rd_addr_a(rd_a2), .rd_addr_b(rd_b2), .tw_idx(tw2),
        .wr_en(wr_en2), .wr_addr_a(wr_a2), .wr_addr_b(wr_b2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int busy, done, stage, rd, a, b, tw, wr, wa, wb;
    } obs_t;

    typedef struct {
        int c, busy, done, rd, a, b, tw, wr, wa, wb;
    } vec_t;

    int   errors = 0;
    int   checks = 0;
    obs_t log1 [0:100];
    vec_t tbl  [13];

    task automatic chk(input string name, input int c, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", name, c, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Butterfly issued on cycle c (c=0 is the start cycle), from the textbook loop nest:
    // for stage s, for group g, for pos in span -> (g*2*span+pos, +span), twiddle pos*32/(2*span).
    function automatic void sched_rd(input int c, input int d, output int rd,
                                     output int a, output int b, output int tw);
        int len, s, off, span, g, pos;
        len = 16 + d;
        rd = 0; a = 0; b = 0; tw = 0;
        if (c >= 1 && c <= 5 * len) begin
            s   = (c - 1) / len;
            off = (c - 1) % len;
            if (off < 16) begin
                span = 2 ** s;
                g    = off / span;
                pos  = off % span;
                rd   = 1;
                a    = g * 2 * span + pos;
                b    = a + span;
                tw   = pos * (32 / (2 * span));
            end
        end
    endfunction

    function automatic void model(input int c, input int d, output obs_t o);
        int len, dc, s, dummy;
        o = '{default: 0};
        len = 16 + d;
        dc  = 1 + 5 * len;
        if (c >= 1 && c <= dc) begin
            o.busy  = 1;
            s       = (c - 1) / len;
            o.stage = (s > 4) ? 4 : s;
        end
        o.done = (c == dc) ? 1 : 0;
        sched_rd(c, d, o.rd, o.a, o.b, o.tw);
        sched_rd(c - d, d, o.wr, o.wa, o.wb, dummy);
    endfunction

    function automatic obs_t get_obs(input int which);
        obs_t o;
        if (which == 1)
            o = '{int'(busy1), int'(done1), int'(stage1), int'(rd_en1), int'(rd_a1),
                  int'(rd_b1), int'(tw1), int'(wr_en1), int'(wr_a1), int'(wr_b1)};
        else
            o = '{int'(busy2), int'(done2), int'(stage2), int'(rd_en2), int'(rd_a2),
                  int'(rd_b2), int'(tw2), int'(wr_en2), int'(wr_a2), int'(wr_b2)};
        return o;
    endfunction

    task automatic cmp_cycle(input int c, input int mc, input int which, input int d);
        obs_t e, g;
        model(mc, d, e);
        g = get_obs(which);
        chk("busy", c, g.busy, e.busy);
        chk("done", c, g.done, e.done);
        chk("rd_en", c, g.rd, e.rd);
        chk("wr_en", c, g.wr, e.wr);
        if (e.busy != 0) chk("stage", c, g.stage, e.stage);
        if (e.rd != 0) begin
            chk("rd_addr_a", c, g.a, e.a);
            chk("rd_addr_b", c, g.b, e.b);
            chk("tw_idx", c, g.tw, e.tw);
        end
        if (e.wr != 0) begin
            chk("wr_addr_a", c, g.wa, e.wa);
            chk("wr_addr_b", c, g.wb, e.wb);
        end
    endtask

    task automatic chk_all_zero(input string name, input int c, input int which);
        obs_t g;
        g = get_obs(which);
        chk({name, "_busy"}, c, g.busy, 0);
        chk({name, "_done"}, c, g.done, 0);
        chk({name, "_stage"}, c, g.stage, 0);
        chk({name, "_rd"}, c, g.rd, 0);
        chk({name, "_addr"}, c, g.a | g.b | g.tw, 0);
        chk({name, "_wr"}, c, g.wr, 0);
        chk({name, "_waddr"}, c, g.wa | g.wb, 0);
    endtask

    initial begin
        int       gap, rc, extra, rd_cnt, wr_cnt, zero_run;
        bit       seen_rd;
        int       gaps[$];
        bit [31:0] mask [5];
        obs_t     g;

        tbl[0]  = '{0,  0, 0, 0, 0,  0,  0,  0, 0,  0};
        tbl[1]  = '{1,  1, 0, 1, 0,  1,  0,  0, 0,  0};
        tbl[2]  = '{2,  1, 0, 1, 2,  3,  0,  0, 0,  0};
        tbl[3]  = '{3,  1, 0, 1, 4,  5,  0,  0, 0,  0};
        tbl[4]  = '{4,  1, 0, 1, 6,  7,  0,  1, 0,  1};
        tbl[5]  = '{17, 1, 0, 0, 0,  0,  0,  1, 26, 27};
        tbl[6]  = '{19, 1, 0, 0, 0,  0,  0,  1, 30, 31};
        tbl[7]  = '{20, 1, 0, 1, 0,  2,  0,  0, 0,  0};
        tbl[8]  = '{44, 1, 0, 1, 9,  13, 4,  1, 2,  6};
        tbl[9]  = '{67, 1, 0, 1, 17, 25, 2,  1, 6,  14};
        tbl[10] = '{92, 1, 0, 1, 15, 31, 15, 1, 12, 28};
        tbl[11] = '{96, 1, 1, 0, 0,  0,  0,  0, 0,  0};
        tbl[12] = '{97, 0, 0, 0, 0,  0,  0,  0, 0,  0};

        rst = 1'b1; start = 1'b0; start2 = 1'b0;
        #1;
        chk_all_zero("reset", 0, 1);
        chk_all_zero("reset2", 0, 2);
        step(); step();
        rst = 1'b0;
        gap = $urandom_range(0, 6);
        for (int i = 0; i < gap; i++) step();

        // Run 1: single start pulse, ignored start pulses during the transform.
        extra = $urandom_range(2, 95);
        rd_cnt = 0; wr_cnt = 0; zero_run = 0; seen_rd = 0;
        for (int s = 0; s < 5; s++) mask[s] = '0;
        for (int c = 0; c <= 100; c++) begin
            start = (c == 0 || c == 10 || c == 96 || c == extra);
            cmp_cycle(c, c, 1, 3);
            g = get_obs(1);
            log1[c] = g;
            if (g.wr != 0) wr_cnt++;
            if (g.rd != 0) begin
                rd_cnt++;
                if (g.stage < 5) begin
                    mask[g.stage][g.a] = 1'b1;
                    mask[g.stage][g.b] = 1'b1;
                end
                if (seen_rd && zero_run > 0) gaps.push_back(zero_run);
                zero_run = 0;
                seen_rd = 1;
            end else if (seen_rd) begin
                zero_run++;
            end
            step();
        end
        start = 1'b0;
        chk("rd_en_count", 100, rd_cnt, 80);
        chk("wr_en_count", 100, wr_cnt, 80);
        for (int s = 0; s < 5; s++) chk("stage_addr_cover", s, int'(mask[s] == 32'hFFFF_FFFF), 1);
        chk("stage_gap_count", 100, gaps.size(), 4);
        foreach (gaps[i]) chk("stage_gap_len", i, gaps[i], 3);

        for (int i = 0; i < 13; i++) begin
            g = log1[tbl[i].c];
            chk("tbl_busy", tbl[i].c, g.busy, tbl[i].busy);
            chk("tbl_done", tbl[i].c, g.done, tbl[i].done);
            chk("tbl_rd_en", tbl[i].c, g.rd, tbl[i].rd);
            chk("tbl_wr_en", tbl[i].c, g.wr, tbl[i].wr);
            if (tbl[i].rd != 0) begin
                chk("tbl_rd_addr_a", tbl[i].c, g.a, tbl[i].a);
                chk("tbl_rd_addr_b", tbl[i].c, g.b, tbl[i].b);
                chk("tbl_tw_idx", tbl[i].c, g.tw, tbl[i].tw);
            end
            if (tbl[i].wr != 0) begin
                chk("tbl_wr_addr_a", tbl[i].c, g.wa, tbl[i].wa);
                chk("tbl_wr_addr_b", tbl[i].c, g.wb, tbl[i].wb);
            end
        end

        // Run 2: start held high -> back-to-back transforms with one IDLE cycle between.
        for (int c = 0; c <= 196; c++) begin
            start = (c < 100);
            cmp_cycle(c, (c < 97) ? c : c - 97, 1, 3);
            step();
        end
        start = 1'b0;

        // Run 3: asynchronous reset in the middle of stage 1 READ.
        rc = $urandom_range(20, 35);
        for (int c = 0; c < rc; c++) begin
            start = (c == 0);
            cmp_cycle(c, c, 1, 3);
            step();
        end
        #2;
        rst = 1'b1;
        #1;
        chk_all_zero("async_rst", rc, 1);
        step();
        rst = 1'b0;
        for (int c = 0; c < 12; c++) begin
            chk("post_rst_wr_en", c, int'(wr_en1), 0);
            chk("post_rst_busy", c, int'(busy1), 0);
            step();
        end
        for (int c = 0; c <= 99; c++) begin
            start = (c == 0);
            cmp_cycle(c, c, 1, 3);
            step();
        end
        start = 1'b0;

        // Run 4: longer pipeline instance (D=5).
        for (int c = 0; c <= 110; c++) begin
            start2 = (c == 0);
            cmp_cycle(c, c, 2, 5);
            if (c == 106) chk("dut2_done_106", c, int'(done2), 1);
            step();
        end
        start2 = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
